// File: rtl/chi_sq_job_sched_if.sv
// Bundle of the job, engine and result handshakes of the chi-squared job scheduler.
// slave is the scheduler's own view; master is the host/engine side that drives it.
interface chi_sq_job_sched_if #(
  parameter int ADDR_W = 8,
  parameter int RES_W  = 32,
  parameter int ID_W   = 4
);
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_base;
  logic [ADDR_W:0]   job_len;
  logic [ID_W-1:0]   job_id;

  logic              eng_clr;
  logic              eng_rdy;
  logic [ADDR_W-1:0] eng_base;
  logic [ADDR_W:0]   eng_len;
  logic              eng_vld;
  logic [RES_W-1:0]  eng_chi;

  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_chi;
  logic [ID_W-1:0]   res_id;
  logic              res_err;

  modport slave (
    input  job_valid, job_base, job_len, job_id, eng_vld, eng_chi, res_ready,
    output job_ready, eng_clr, eng_rdy, eng_base, eng_len,
           res_valid, res_chi, res_id, res_err
  );

  modport master (
    output job_valid, job_base, job_len, job_id, eng_vld, eng_chi, res_ready,
    input  job_ready, eng_clr, eng_rdy, eng_base, eng_len,
           res_valid, res_chi, res_id, res_err
  );
endinterface

// File: rtl/chi_sq_job_sched.sv
// Job scheduler for the chi-squared engine: descriptor queue, one-job-at-a-time sequencer, tagged results.
// Define CHI_SQ_TIMEOUT_EN to add a RUN watchdog that aborts a job after TIMEOUT cycles with res_err=1.
module chi_sq_job_sched #(
  parameter int QDEPTH  = 4,
  parameter int ADDR_W  = 8,
  parameter int RES_W   = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  chi_sq_job_sched_if.slave   bus,
  output logic                busy,
  output logic [15:0]         jobs_done
);

  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DESC_W = ADDR_W + (ADDR_W + 1) + ID_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_ABORT,
    S_RESULT
  } state_t;

  state_t            state_q, state_d;

  logic [DESC_W-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              q_full, q_empty;
  logic              push, pop;

  logic [ADDR_W-1:0] head_base;
  logic [ADDR_W:0]   head_len;
  logic [ID_W-1:0]   head_id;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [RES_W-1:0]  chi_q, chi_d;
  logic [15:0]       done_q, done_d;
  logic              wd_expire;

  // Descriptor queue; readiness comes from the registered count only, so a full
  // queue refuses a push even in the cycle that frees a slot.
  assign q_full  = (count_q == CNT_W'(QDEPTH));
  assign q_empty = (count_q == '0);
  assign push    = bus.job_valid && !q_full;
  assign {head_base, head_len, head_id} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.job_base, bus.job_len, bus.job_id};
  end

`ifdef CHI_SQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // wd_q counts completed RUN cycles; expiry lands on the TIMEOUT-th one.
  assign wd_expire = (state_q == S_RUN) && (wd_q == WD_W'(TIMEOUT - 1));
  assign wd_d      = (state_q == S_RUN) ? wd_q + 1'b1 : '0;
  assign bus.res_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign wd_expire      = 1'b0;
  assign bus.res_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    id_d    = id_q;
    chi_d   = chi_q;
    done_d  = done_q;
    pop     = 1'b0;
`ifdef CHI_SQ_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          pop  = 1'b1;
          id_d = head_id;
`ifdef CHI_SQ_TIMEOUT_EN
          err_d = 1'b0;
`endif
          // Zero-length jobs never reach the engine, so its address/length stay as they were.
          if (head_len == '0) begin
            chi_d   = '0;
            state_d = S_RESULT;
          end else begin
            base_d  = head_base;
            len_d   = head_len;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (bus.eng_vld) begin
          chi_d   = bus.eng_chi;
          state_d = S_RESULT;
        end else if (wd_expire) begin
          chi_d   = '1;
`ifdef CHI_SQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
          state_d = S_ABORT;
        end
      end
      S_ABORT: state_d = S_RESULT;
      S_RESULT: begin
        if (bus.res_ready) begin
          done_d  = done_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      base_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      chi_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      base_q   <= base_d;
      len_q    <= len_d;
      id_q     <= id_d;
      chi_q    <= chi_d;
      done_q   <= done_d;
    end
  end

  // Engine controls decode straight from the state register so a reset drops them at once.
  assign bus.job_ready = !q_full;
  assign bus.eng_clr   = (state_q == S_CLEAR) || (state_q == S_ABORT);
  assign bus.eng_rdy   = (state_q == S_RUN);
  assign bus.eng_base  = base_q;
  assign bus.eng_len   = len_q;
  assign bus.res_valid = (state_q == S_RESULT);
  assign bus.res_chi   = chi_q;
  assign bus.res_id    = id_q;
  assign busy          = (state_q != S_IDLE) || !q_empty;
  assign jobs_done     = done_q;

endmodule

// File: tb/tb_chi_sq_job_sched.sv
// Self-checking bench for chi_sq_job_sched: vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model with an engine model.
module tb_chi_sq_job_sched;
  localparam int QDEPTH  = 4;
  localparam int ADDR_W  = 8;
  localparam int RES_W   = 32;
  localparam int ID_W    = 4;
  localparam int TIMEOUT = 64;
  localparam int NRAND   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] jobs_done;

  chi_sq_job_sched_if #(.ADDR_W(ADDR_W), .RES_W(RES_W), .ID_W(ID_W)) bus ();

  chi_sq_job_sched #(
    .QDEPTH(QDEPTH), .ADDR_W(ADDR_W), .RES_W(RES_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;

  // engine model state
  int          n_clr = 0;
  int          n_rdy = 0;
  int          run_cnt = 0;
  int          eng_delay = 0;      // 0 = stall forever
  logic [31:0] eng_ret = 32'h0;
  bit          eng_fixed = 1'b1;   // 1: return eng_ret, 0: return chi_fn(base,len)
  bit          eng_rand = 1'b0;    // pick a fresh delay per job
  bit          spur = 1'b0;        // pulse eng_vld during CLEAR with a wrong value

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [3:0]  id;
    int          delay;
    logic [31:0] ret;
    bit          spur;
    logic [31:0] exp_chi;
    int          exp_clr;
    int          exp_rdy;
  } vec_t;

  vec_t tbl [6];

  logic [31:0] rq_chi [$];
  logic [3:0]  rq_id [$];

  function automatic logic [31:0] chi_fn(input logic [7:0] b, input logic [8:0] l);
    return 32'hA500_0000 ^ {11'd0, b, 13'd0} ^ {23'd0, l};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: counts eng_rdy cycles since the last clear, answers after eng_delay of them.
  initial begin
    bit vld;
    bus.eng_vld = 1'b0;
    bus.eng_chi = '0;
    forever begin
      @(negedge clk);
      vld = 1'b0;
      if (bus.eng_clr) begin
        run_cnt = 0;
        n_clr++;
        if (eng_rand) eng_delay = $urandom_range(1, 8);
      end
      if (bus.eng_rdy) begin
        run_cnt++;
        n_rdy++;
      end
      if (bus.eng_rdy && eng_delay != 0 && run_cnt >= eng_delay) vld = 1'b1;
      bus.eng_chi = eng_fixed ? eng_ret : chi_fn(bus.eng_base, bus.eng_len);
      if (spur && bus.eng_clr) begin
        vld = 1'b1;
        bus.eng_chi = ~eng_ret;
      end
      bus.eng_vld = vld;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: sim still running, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic push_job(input logic [7:0] b, input logic [8:0] l, input logic [3:0] id);
    int n = 0;
    bus.job_base  = b;
    bus.job_len   = l;
    bus.job_id    = id;
    bus.job_valid = 1'b1;
    while (!bus.job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", bus.job_ready, 1);
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [31:0] e_chi, input logic [3:0] e_id,
                             input logic e_err, input string tag);
    int n = 0;
    while (!bus.res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, bus.res_valid, 1);
    check({tag, "_chi"}, bus.res_chi, e_chi);
    check({tag, "_id"}, bus.res_id, e_id);
    check({tag, "_err"}, bus.res_err, e_err);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_done++;
    check({tag, "_jobs_done"}, jobs_done, 16'(exp_done));
  endtask

  initial begin
    int c0, r0, n;
    bit stable;
    bus.job_valid = 1'b0;
    bus.job_base  = '0;
    bus.job_len   = '0;
    bus.job_id    = '0;
    bus.res_ready = 1'b0;

    tbl[0] = '{8'h00, 9'd16,  4'd3,  20, 32'h0000_1234, 1'b0, 32'h0000_1234, 1, 20};
    tbl[1] = '{8'h40, 9'd0,   4'd7,  5,  32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 0, 0};
    tbl[2] = '{8'hFF, 9'd256, 4'd15, 1,  32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 1, 1};
    tbl[3] = '{8'h10, 9'd1,   4'd0,  3,  32'h8000_0001, 1'b1, 32'h8000_0001, 1, 3};
    tbl[4] = '{8'h80, 9'd100, 4'd9,  7,  32'h0000_0000, 1'b0, 32'h0000_0000, 1, 7};
    tbl[5] = '{8'h7E, 9'd255, 4'd12, 2,  32'h1357_9BDF, 1'b1, 32'h1357_9BDF, 1, 2};

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_eng_clr", bus.eng_clr, 0);
    check("rst_eng_rdy", bus.eng_rdy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_chi", bus.res_chi, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_eng_len", bus.eng_len, 0);
    check("rst_jobs_done", jobs_done, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      eng_fixed = 1'b1;
      eng_delay = tbl[i].delay;
      eng_ret   = tbl[i].ret;
      spur      = tbl[i].spur;
      c0 = n_clr;
      r0 = n_rdy;
      push_job(tbl[i].base, tbl[i].len, tbl[i].id);
      wait_result(tbl[i].exp_chi, tbl[i].id, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_clr_pulses", i), n_clr - c0, tbl[i].exp_clr);
      check($sformatf("vec%0d_rdy_cycles", i), n_rdy - r0, tbl[i].exp_rdy);
    end
    spur = 1'b0;

    // Latency from an idle, empty queue: push in cycle 0.
    eng_fixed = 1'b1;
    eng_ret   = 32'h0BAD_F00D;
    eng_delay = 5;
    check("lat_c0_ready", bus.job_ready, 1);
    bus.job_base  = 8'hC3;
    bus.job_len   = 9'd256;
    bus.job_id    = 4'd5;
    bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    check("lat_c1_clr", bus.eng_clr, 0);
    check("lat_c1_busy", busy, 1);
    @(negedge clk);
    check("lat_c2_clr", bus.eng_clr, 1);
    check("lat_c2_rdy", bus.eng_rdy, 0);
    @(negedge clk);
    check("lat_c3_rdy", bus.eng_rdy, 1);
    check("lat_c3_clr", bus.eng_clr, 0);
    check("lat_c3_base", bus.eng_base, 8'hC3);
    check("lat_c3_len", bus.eng_len, 9'd256);
    repeat (4) @(negedge clk);
    check("lat_c7_rdy", bus.eng_rdy, 1);
    check("lat_c7_res_valid", bus.res_valid, 0);
    @(negedge clk);
    check("lat_c8_res_valid", bus.res_valid, 1);
    check("lat_c8_rdy", bus.eng_rdy, 0);
    wait_result(32'h0BAD_F00D, 4'd5, 1'b0, "lat");

    // Back-pressure: engine stalled, one job in flight plus QDEPTH queued, then one held.
    eng_fixed = 1'b0;
    eng_delay = 0;
    for (int k = 0; k < 6; k++) begin
      bus.job_base  = 8'(k * 16);
      bus.job_len   = 9'(k + 1);
      bus.job_id    = 4'(k + 1);
      bus.job_valid = 1'b1;
      check($sformatf("bp_ready%0d", k), bus.job_ready, (k < 5) ? 1 : 0);
      if (k < 5) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("bp_still_full", bus.job_ready, 0);
    check("bp_stalled_rdy", bus.eng_rdy, 1);
    eng_delay = 2;
    wait_result(chi_fn(8'h00, 9'd1), 4'd1, 1'b0, "bp0");
    check("bp_no_pushthrough", bus.job_ready, 0);
    @(negedge clk);
    check("bp_ready_after_pop", bus.job_ready, 1);
    @(negedge clk);
    bus.job_valid = 1'b0;
    for (int k = 1; k < 6; k++)
      wait_result(chi_fn(8'(k * 16), 9'(k + 1)), 4'(k + 1), 1'b0, $sformatf("bp%0d", k));

    // Result held by res_ready low for 10 cycles with another job waiting.
    eng_delay = 4;
    push_job(8'h21, 9'd8, 4'hA);
    push_job(8'h22, 9'd9, 4'hB);
    n = 0;
    while (!bus.res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid", bus.res_valid, 1);
    check("hold_chi", bus.res_chi, chi_fn(8'h21, 9'd8));
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_chi !== chi_fn(8'h21, 9'd8) || bus.res_id !== 4'hA ||
          bus.eng_rdy || bus.eng_clr) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_id", bus.res_id, 4'hA);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_done++;
    check("hold_jobs_done", jobs_done, 16'(exp_done));
    check("hold_h1_clr", bus.eng_clr, 0);
    @(negedge clk);
    check("hold_h2_clr", bus.eng_clr, 1);
    wait_result(chi_fn(8'h22, 9'd9), 4'hB, 1'b0, "hold_next");

`ifdef CHI_SQ_TIMEOUT_EN
    // Watchdog: engine never answers; then an answer landing on the expiry cycle.
    eng_delay = 0;
    c0 = n_clr;
    r0 = n_rdy;
    push_job(8'h05, 9'd20, 4'h2);
    wait_result(32'hFFFF_FFFF, 4'h2, 1'b1, "wd");
    check("wd_rdy_cycles", n_rdy - r0, TIMEOUT);
    check("wd_clr_pulses", n_clr - c0, 2);
    check("wd_rdy_low", bus.eng_rdy, 0);
    eng_delay = TIMEOUT;
    r0 = n_rdy;
    push_job(8'h06, 9'd21, 4'h3);
    wait_result(chi_fn(8'h06, 9'd21), 4'h3, 1'b0, "wd_race");
    check("wd_race_rdy_cycles", n_rdy - r0, TIMEOUT);
`endif

    // Asynchronous reset during RUN with two jobs queued.
    eng_delay = 0;
    push_job(8'h31, 9'd4, 4'h1);
    push_job(8'h32, 9'd4, 4'h2);
    push_job(8'h33, 9'd4, 4'h3);
    n = 0;
    while (!bus.eng_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("arst_pre_rdy", bus.eng_rdy, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_rdy", bus.eng_rdy, 0);
    check("arst_job_ready", bus.job_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_res_valid", bus.res_valid, 0);
    check("arst_jobs_done", jobs_done, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_done = 0;
    eng_delay = 3;
    @(negedge clk);
    push_job(8'h44, 9'd12, 4'h6);
    wait_result(chi_fn(8'h44, 9'd12), 4'h6, 1'b0, "arst_after");
    repeat (3) @(negedge clk);
    check("arst_no_ghost_jobs", busy, 0);

    // Randomized traffic against the queue reference model.
    eng_rand = 1'b1;
    fork
      begin
        logic [7:0] b;
        logic [8:0] l;
        logic [3:0] id;
        for (int j = 0; j < NRAND; j++) begin
          b  = 8'($urandom);
          l  = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 256));
          id = 4'($urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_job(b, l, id);
          rq_chi.push_back((l == 0) ? 32'h0 : chi_fn(b, l));
          rq_id.push_back(id);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        bit rr;
        logic [31:0] e_chi;
        logic [3:0]  e_id;
        while (got < NRAND && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          rr = 1'($urandom_range(0, 1));
          bus.res_ready = rr;
          if (bus.res_valid && rr) begin
            if (rq_chi.size() == 0) begin
              check("rnd_unexpected_result", bus.res_valid, 0);
            end else begin
              e_chi = rq_chi.pop_front();
              e_id  = rq_id.pop_front();
              check($sformatf("rnd%0d_chi", got), bus.res_chi, e_chi);
              check($sformatf("rnd%0d_id", got), bus.res_id, e_id);
            end
            got++;
            exp_done++;
          end
        end
        check("rnd_result_count", got, NRAND);
        @(negedge clk);
        bus.res_ready = 1'b0;
      end
    join
    check("rnd_jobs_done", jobs_done, 16'(exp_done));
    check("rnd_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
